// File: rtl/mix_columns_seq.sv
// ============================================================================
// Module   : mix_columns_seq
// Purpose  : Streams a 128-bit AES state through a shared 32-bit MixColumns
//            column unit, one column per cycle, and reassembles the results.
//            Optional macro MIX_LAST_ROUND_BYPASS_EN: states flagged as the
//            final round skip the column unit and are returned unchanged.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mix_columns_seq #(
  parameter int COL_LAT = 1  // column-unit latency, legal range 1..8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         col_valid_o,
  output logic [31:0]  col_data_o,
  input  logic [31:0]  col_data_i,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t       r_state;
  logic [127:0] r_src;        // latched input state, source of issued columns
  logic [1:0]   r_cnt;        // index of the column currently on col_data_o
  logic [2:0]   r_tag [COL_LAT]; // {valid, column index} per outstanding issue

  logic         w_accept;
  logic         w_bypass;
  logic         w_tap_vld;
  logic [1:0]   w_tap_idx;

  // Column k of a state; column 0 occupies the most significant word.
  function automatic logic [31:0] col_sel(input logic [127:0] s, input logic [1:0] k);
    col_sel = s[127:96];
    case (k)
      2'd0: col_sel = s[127:96];
      2'd1: col_sel = s[95:64];
      2'd2: col_sel = s[63:32];
      2'd3: col_sel = s[31:0];
      default: col_sel = s[127:96];
    endcase
  endfunction

`ifdef MIX_LAST_ROUND_BYPASS_EN
  assign w_bypass = in_last;
`else
  // Final-round flag has no effect in this build.
  logic w_unused_in_last;
  assign w_unused_in_last = in_last;
  assign w_bypass         = 1'b0;
`endif

  assign w_accept  = (r_state == ST_IDLE) && in_valid && in_ready;
  assign w_tap_vld = r_tag[COL_LAT-1][2];
  assign w_tap_idx = r_tag[COL_LAT-1][1:0];
  assign busy      = (r_state != ST_IDLE);

  // Control FSM: accept, issue four columns, wait for returns, hand off result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_src       <= '0;
      r_cnt       <= 2'd0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      col_valid_o <= 1'b0;
      col_data_o  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_src    <= in_state;
            in_ready <= 1'b0;
            if (w_bypass) begin
              out_valid <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              col_valid_o <= 1'b1;
              col_data_o  <= in_state[127:96];
              r_cnt       <= 2'd0;
              r_state     <= ST_ISSUE;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (r_cnt == 2'd3) begin
            // Counter wraps only here; col_data_o keeps column 3.
            col_valid_o <= 1'b0;
            r_cnt       <= 2'd0;
            r_state     <= ST_DRAIN;
          end else begin
            r_cnt      <= r_cnt + 2'd1;
            col_data_o <= col_sel(r_src, r_cnt + 2'd1);
          end
        end
        ST_DRAIN: begin
          // Columns return in issue order, so column 3 is always the last.
          if (w_tap_vld && (w_tap_idx == 2'd3)) begin
            out_valid <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Issue-tag delay line aligned with the column unit latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < COL_LAT; i++) r_tag[i] <= 3'b000;
    end else begin
      r_tag[0] <= {col_valid_o, r_cnt};
      for (int i = 1; i < COL_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Result register: returned columns land in their slot; bypass loads whole state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state <= '0;
    end else if (w_accept && w_bypass) begin
      out_state <= in_state;
    end else if (w_tap_vld) begin
      case (w_tap_idx)
        2'd0: out_state[127:96] <= col_data_i;
        2'd1: out_state[95:64]  <= col_data_i;
        2'd2: out_state[63:32]  <= col_data_i;
        2'd3: out_state[31:0]   <= col_data_i;
        default: out_state[127:96] <= col_data_i;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
// ============================================================================
// Module   : tb_mix_columns_seq
// Purpose  : Self-checking bench for mix_columns_seq. Two instances are used,
//            COL_LAT=1 (index 0) and COL_LAT=4 (index 1), each paired with a
//            behavioural MixColumns column unit. Honours the
//            MIX_LAST_ROUND_BYPASS_EN macro when forming expectations.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mix_columns_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]        in_valid, in_last, out_ready;
  logic [1:0]        in_ready, out_valid, col_valid, busy;
  logic [1:0][127:0] in_state, out_state;
  logic [1:0][31:0]  col_out, col_rsp;
  logic [31:0]       pipe [2][8];

  int n_cmp = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int t0 [2];

  typedef struct {
    int           d;
    logic [127:0] st;
    logic         last;
    logic [127:0] exp;
    int           hold;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  mix_columns_seq #(.COL_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_state(in_state[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_state(out_state[0]),
    .col_valid_o(col_valid[0]), .col_data_o(col_out[0]), .col_data_i(col_rsp[0]), .busy(busy[0])
  );

  mix_columns_seq #(.COL_LAT(4)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_state(in_state[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_state(out_state[1]),
    .col_valid_o(col_valid[1]), .col_data_o(col_out[1]), .col_data_i(col_rsp[1]), .busy(busy[1])
  );

  // AES MixColumns reference arithmetic in GF(2^8)
  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    mix_col = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
               a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
               xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] mix_state(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[127-32*k -: 32] = mix_col(s[127-32*k -: 32]);
    mix_state = r;
  endfunction

  function automatic logic [127:0] exp_for(input logic [127:0] s, input logic last);
    logic byp;
    byp = 1'b0;
`ifdef MIX_LAST_ROUND_BYPASS_EN
    byp = last;
`endif
    exp_for = (byp || 1'b0) ? s : mix_state(s);
    if (!byp && last) exp_for = mix_state(s);
  endfunction

  function automatic int lat_of(input int d);
    lat_of = (d == 0) ? 1 : 4;
  endfunction

  // Column unit models: pure pipelines, result visible COL_LAT cycles after issue
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pipe[d][0] <= mix_col(col_out[d]);
      for (int i = 1; i < 8; i++) pipe[d][i] <= pipe[d][i-1];
    end
  end
  assign col_rsp[0] = pipe[0][0];
  assign col_rsp[1] = pipe[1][3];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_in_ready%0d", tag, d), in_ready[d], 0);
      chk($sformatf("%s_out_valid%0d", tag, d), out_valid[d], 0);
      chk($sformatf("%s_out_state%0d", tag, d), out_state[d], 0);
      chk($sformatf("%s_col_valid%0d", tag, d), col_valid[d], 0);
      chk($sformatf("%s_col_data%0d", tag, d), col_out[d], 0);
      chk($sformatf("%s_busy%0d", tag, d), busy[d], 0);
    end
  endtask

  // One full transaction on instance d with cycle-accurate checks
  task automatic run_txn(input int d, input logic [127:0] st, input logic last,
                         input logic [127:0] exp, input int hold);
    int n, pulses, to, want_lat, want_pulses;
    logic byp;
    logic [127:0] shadow;
    byp = 1'b0;
`ifdef MIX_LAST_ROUND_BYPASS_EN
    byp = last;
`endif
    want_lat    = byp ? 1 : 5 + lat_of(d);
    want_pulses = byp ? 0 : 4;
    to = 0;
    while (in_ready[d] !== 1'b1 && to < 64) begin @(negedge clk); to++; end
    chk($sformatf("accept_ready%0d", d), in_ready[d], 1);
    in_valid[d] = 1'b1; in_state[d] = st; in_last[d] = last; out_ready[d] = (hold == 0);
    @(posedge clk); #1;
    t0[d] = edge_cnt;
    in_valid[d] = 1'b0;
    in_state[d] = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_last[d]  = 1'($urandom_range(0, 1));
    n = 0; pulses = 0;
    do begin
      @(negedge clk); n++;
      if (col_valid[d]) begin
        if (pulses < 4) chk($sformatf("col_order%0d_d%0d", pulses, d), col_out[d], st[127-32*pulses -: 32]);
        pulses++;
      end
    end while (!out_valid[d] && n < 40);
    chk($sformatf("out_valid_seen%0d", d), out_valid[d], 1);
    chk($sformatf("latency%0d", d), n, want_lat);
    chk($sformatf("col_pulses%0d", d), pulses, want_pulses);
    chk($sformatf("out_state%0d", d), out_state[d], exp);
    chk($sformatf("in_ready_low%0d", d), in_ready[d], 0);
    chk($sformatf("busy_high%0d", d), busy[d], 1);
    if (hold > 0) begin
      shadow = out_state[d];
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk($sformatf("bp_stable%0d", d), out_state[d], shadow);
        chk($sformatf("bp_valid%0d", d), out_valid[d], 1);
        chk($sformatf("bp_in_ready%0d", d), in_ready[d], 0);
      end
      out_ready[d] = 1'b1;
    end
    @(negedge clk);
    chk($sformatf("post_valid%0d", d), out_valid[d], 0);
    chk($sformatf("post_in_ready%0d", d), in_ready[d], 1);
    chk($sformatf("post_busy%0d", d), busy[d], 0);
    out_ready[d] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_t0;
    bit saw_valid;
    logic [127:0] rs;
    logic rl;
    int rd;

    in_valid = '0; in_last = '0; out_ready = '0; in_state = '0;

    vecs[0] = '{0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 0};
    vecs[1] = '{1, 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, 1'b0, 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6, 0};
    vecs[2] = '{0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 10};
    vecs[3] = '{1, 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, 1'b0, 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6, 10};
    vecs[4] = '{0, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, exp_for(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1), 0};
    vecs[5] = '{1, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, exp_for(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1), 2};

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready0", in_ready[0], 0);
    @(negedge clk);
    chk("first_in_ready0", in_ready[0], 1);
    chk("first_in_ready1", in_ready[1], 1);

    // Table-driven vectors
    for (int v = 0; v < 6; v++) run_txn(vecs[v].d, vecs[v].st, vecs[v].last, vecs[v].exp, vecs[v].hold);

    // Back-to-back with out_ready held high
    for (int d = 0; d < 2; d++) begin
      rs = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_txn(d, rs, 1'b0, mix_state(rs), 0);
      first_t0 = t0[d];
      rs = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_txn(d, rs, 1'b0, mix_state(rs), 0);
      chk($sformatf("b2b_interval%0d", d), t0[d] - first_t0, lat_of(d) + 6);
    end

    // Reset during ISSUE at column 2, both instances
    @(negedge clk);
    in_valid = 2'b11; in_last = 2'b00;
    in_state[0] = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    in_state[1] = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
    @(posedge clk); #1;
    in_valid = 2'b00;
    repeat (3) @(negedge clk);
    chk("abort_col2_d0", col_out[0], 32'h01010101);
    chk("abort_col2_d1", col_out[1], 32'h01010101);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid != 2'b00 || busy != 2'b00) saw_valid = 1'b1;
    end
    chk("abort_no_out_valid", saw_valid, 0);
    run_txn(0, vecs[0].st, 1'b0, vecs[0].exp, 0);
    run_txn(1, vecs[1].st, 1'b0, vecs[1].exp, 0);

    // Randomized traffic against the reference model
    for (int r = 0; r < 24; r++) begin
      rd = $urandom_range(0, 1);
      rs = {$urandom(), $urandom(), $urandom(), $urandom()};
      rl = 1'($urandom_range(0, 1));
      run_txn(rd, rs, rl, exp_for(rs, rl), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mix_columns_seq.md
# mix_columns_seq

Sequencer that runs a full 128-bit AES state through a single 32-bit MixColumns column unit, one column per cycle. It sits between the ShiftRows stage and AddRoundKey in the round datapath. It accepts a state over a valid/ready handshake, issues the four columns to the shared column unit, and reassembles the returned columns. It then presents the mixed state over a second valid/ready handshake.

## Interface
- `COL_LAT`, default 1: cycles from a column issued on `col_data_o` to its result on `col_data_i`; legal range 1..8.
- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_state` is valid.
- `in_ready` output 1: block can accept a state; high only in IDLE.
- `in_state` input 128: column 0 = [127:96], column 1 = [95:64], column 2 = [63:32], column 3 = [31:0]; byte 0 of each column in the MSBs.
- `in_last` input 1: final AES round flag, sampled with `in_state`.
- `out_valid` output 1: `out_state` is valid.
- `out_ready` input 1: downstream accepts `out_state`.
- `out_state` output 128: mixed state, same column layout as `in_state`.
- `col_valid_o` output 1: a column is being issued this cycle.
- `col_data_o` output 32: column sent to the column unit.
- `col_data_i` input 32: column-unit result, valid exactly `COL_LAT` cycles after issue.
- `busy` output 1: FSM not in IDLE.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, latch `in_state` and go to ISSUE.
  - ISSUE: lasts exactly 4 cycles. `col_valid_o`=1 and `col_data_o` = column k in the k-th cycle (k=0..3). Then go to DRAIN.
  - DRAIN: wait for outstanding returns. Go to DONE on the cycle the 4th result is captured (next state).
  - DONE: `out_valid`=1 with `out_state` stable. When `out_ready`=1, return to IDLE.
- Result capture:
  - A `COL_LAT`-deep shift register of issue tags (valid bit plus 2-bit column index) tracks outstanding columns.
  - When the tap is valid, `col_data_i` is written to the indicated column slot of the result register.
- Column unit contract:
  - The unit is pure pipeline, no back-pressure.
  - The block never issues while a previous state is outstanding, so the unit sees at most 4 columns in flight.
- `col_data_o` holds its last value when `col_valid_o`=0.
- Bytes are passed untouched; no arithmetic in this block beyond the 2-bit column counter.
  - The counter wraps 3→0 only on leaving ISSUE.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.

## Timing
- Let T0 be the edge where `in_valid` && `in_ready`.
- Column k is issued in cycle T0+1+k and its result is captured at the end of cycle T0+1+k+`COL_LAT`.
- `out_valid` rises in cycle T0+5+`COL_LAT`; latency is 6 cycles at `COL_LAT`=1.
- The minimum accept-to-accept interval is `COL_LAT`+6 cycles with `out_ready` held at 1.
- Reset values: `in_ready`=0 during reset and 1 in the first cycle after release. `out_valid`=0, `out_state`=0, `col_valid_o`=0, `col_data_o`=0, `busy`=0. Tag pipeline and result register are cleared.
- Reset mid-operation:
  - Aborts immediately.
  - Returns arriving after release are discarded because their tags are cleared.
- `out_ready` high in the same cycle `out_valid` first rises completes the transfer at that edge.
- `out_valid` never drops without `out_ready`.

## Configuration
- `MIX_LAST_ROUND_BYPASS_EN` defined:
  - A state accepted with `in_last`=1 skips ISSUE and DRAIN.
  - IDLE→DONE with `out_state` = `in_state` unchanged.
  - `out_valid` is high in cycle T0+1.
  - `col_valid_o` stays 0 for that state.
- `MIX_LAST_ROUND_BYPASS_EN` undefined:
  - `in_last` is ignored.
  - Every state takes the full column path.

## Test plan
- Known vector, `COL_LAT`=1, bench column model:
  - Stimulus: `in_state`=db135345_f20a225c_01010101_c6c6c6c6.
  - Response: `out_state`=8e4da1bc_9fdc589d_01010101_c6c6c6c6 with `out_valid` at T0+6.
  - Exactly 4 `col_valid_o` pulses in column order 0..3.
- `COL_LAT`=4:
  - Stimulus: `in_state`=d4d4d4d5_2d26314c_01010101_c6c6c6c6.
  - Response: `out_state`=d5d5d7d6_4d7ebdf8_01010101_c6c6c6c6 at T0+9.
- Back-pressure:
  - Stimulus: `out_ready`=0 for 10 cycles after `out_valid`.
  - Response: `out_state` stable, `in_ready`=0 throughout, accept completes on the first `out_ready`=1 edge, `in_ready`=1 the next cycle.
- Reset mid-operation:
  - Stimulus: `rst_n` pulsed low during ISSUE at column 2.
  - Response: all outputs return to reset values asynchronously; no `out_valid` for the aborted state; the next state processes correctly.
- Bypass, macro defined:
  - Stimulus: `in_last`=1 with `in_state`=00112233_44556677_8899aabb_ccddeeff.
  - Response: identical `out_state` at T0+1, `col_valid_o` never asserted.
  - Without the macro, the same stimulus produces the fully mixed result.
- Back-to-back:
  - Stimulus: two states with `out_ready` tied to 1.
  - Response: the second accept occurs exactly `COL_LAT`+6 cycles after the first; both results are correct.
